// File: rtl/cfg_shift_loader.sv
// Serial configuration loader: shifts a dynamic then a static word MSB-first with a divided SCLK.
// Optional build macro CFG_LOADER_REPEAT_EN lets DONE return to IDLE for repeated loads.
module cfg_shift_loader #(
  parameter int                DYN_W     = 16,
  parameter int                STAT_W    = 88,
  parameter logic [DYN_W-1:0]  DYN_INIT  = 16'hABC6,
  parameter logic [STAT_W-1:0] STAT_INIT = 88'h123456789ABCDEF1234567,
  parameter int                IDLE_WAIT = 200,
  parameter int                CLK_DIV   = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             flag_input,
  input  logic [1:0]       mode,
  input  logic             dyn_wr,
  input  logic [DYN_W-1:0] dyn_wdata,
  output logic             SCLK,
  output logic             SEL,
  output logic             MOSI,
  output logic             busy,
  output logic             done
);

  localparam int MAX_W     = (DYN_W > STAT_W) ? DYN_W : STAT_W;
  localparam int DIV_BITS  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_BITS  = $clog2(MAX_W + 1);
  localparam int WAIT_BITS = (IDLE_WAIT > 0) ? $clog2(IDLE_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DYN,
    S_GAP,
    S_STAT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WAIT_BITS-1:0] wait_q, wait_d;
  logic [DIV_BITS-1:0]  div_q, div_d;
  logic                 phase_q, phase_d;
  logic [BIT_BITS-1:0]  bit_q, bit_d;
  logic [MAX_W-1:0]     shreg_q, shreg_d;
  logic [1:0]           mode_q, mode_d;
  logic [DYN_W-1:0]     shadow_q, shadow_d;
  logic                 flag_q, flag_d;
  logic                 sclk_q, sclk_d;
  logic                 sel_q, sel_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tick;
  logic                 fall;
  logic [MAX_W-1:0]     dyn_aligned;
  logic [MAX_W-1:0]     stat_aligned;
  logic [DYN_W-1:0]     dyn_src;

  // Words are left-aligned in a shared shift register so MOSI is always its MSB.
  always_comb begin
    dyn_src = dyn_wr ? dyn_wdata : shadow_q;
    dyn_aligned = '0;
    dyn_aligned[MAX_W-1 -: DYN_W] = dyn_src;
    stat_aligned = '0;
    stat_aligned[MAX_W-1 -: STAT_W] = STAT_INIT;
  end

  assign tick = (div_q == DIV_BITS'(CLK_DIV - 1));
  assign fall = tick & phase_q;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    mode_d   = mode_q;
    shadow_d = shadow_q;
    flag_d   = flag_input;

    if (dyn_wr && (state_q == S_IDLE || state_q == S_DONE)) begin
      shadow_d = dyn_wdata;
    end

    // The divider runs in GAP too, so GAP lasts exactly one SCLK period.
    if (state_q == S_DYN || state_q == S_GAP || state_q == S_STAT) begin
      if (tick) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + DIV_BITS'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (wait_q < WAIT_BITS'(IDLE_WAIT)) begin
          wait_d = wait_q + WAIT_BITS'(1);
        end
        if (flag_q && (wait_q >= WAIT_BITS'(IDLE_WAIT))) begin
          mode_d  = mode;
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          if (mode == 2'b10) begin
            state_d = S_STAT;
            shreg_d = stat_aligned;
          end else begin
            state_d = S_DYN;
            shreg_d = dyn_aligned;
          end
        end
      end
      S_DYN: begin
        if (fall) begin
          shreg_d = shreg_q << 1;
          if (bit_q == BIT_BITS'(DYN_W - 1)) begin
            bit_d   = '0;
            state_d = (mode_q == 2'b01) ? S_DONE : S_GAP;
          end else begin
            bit_d = bit_q + BIT_BITS'(1);
          end
        end
      end
      S_GAP: begin
        if (fall) begin
          state_d = S_STAT;
          shreg_d = stat_aligned;
          bit_d   = '0;
        end
      end
      S_STAT: begin
        if (fall) begin
          shreg_d = shreg_q << 1;
          if (bit_q == BIT_BITS'(STAT_W - 1)) begin
            bit_d   = '0;
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + BIT_BITS'(1);
          end
        end
      end
      S_DONE: begin
`ifdef CFG_LOADER_REPEAT_EN
        if (!flag_q) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with state_q.
  always_comb begin
    sclk_d = (state_d == S_DYN || state_d == S_STAT) && phase_d;
    sel_d  = (state_d != S_IDLE) && (state_d != S_STAT);
    mosi_d = (state_d == S_DYN || state_d == S_STAT) && shreg_d[MAX_W-1];
    busy_d = (state_d == S_DYN || state_d == S_GAP || state_d == S_STAT);
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      div_q    <= '0;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      shreg_q  <= '0;
      mode_q   <= 2'b00;
      shadow_q <= DYN_INIT;
      flag_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sel_q    <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      flag_q   <= flag_d;
      sclk_q   <= sclk_d;
      sel_q    <= sel_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign SCLK = sclk_q;
  assign SEL  = sel_q;
  assign MOSI = mosi_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_cfg_shift_loader.sv
// Directed bench for cfg_shift_loader: table of load vectors plus hand-written reset/timing sequences.
module tb_cfg_shift_loader;

  logic        clk;
  logic        rst_n;
  logic        flag_input;
  logic [1:0]  mode;
  logic        dyn_wr;
  logic [15:0] dyn_wdata;
  logic        sclk, sel, mosi, busy, done;

  int checks;
  int failures;

  localparam logic [87:0] STAT_WORD = 88'h123456789ABCDEF1234567;

  cfg_shift_loader dut (
    .CLK(clk), .RST_N(rst_n), .flag_input(flag_input), .mode(mode),
    .dyn_wr(dyn_wr), .dyn_wdata(dyn_wdata),
    .SCLK(sclk), .SEL(sel), .MOSI(mosi), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    bit          wr;
    logic [15:0] wval;
    int          exp_nd;
    logic [15:0] exp_dw;
    int          exp_ns;
    logic [87:0] exp_sw;
    int          exp_cyc;
    int          exp_gap;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs from the first busy sample until the done pulse, recording bits on SCLK rising edges.
  task automatic collect(input bit wr_mid, output int nd, output logic [15:0] dw,
                         output int ns, output logic [87:0] sw, output int cyc,
                         output int gap, output int dones, output int selviol, output bit to);
    logic prev_sclk, prev_sel;
    nd = 0; ns = 0; dw = '0; sw = '0; cyc = 0; gap = 0; dones = 0; selviol = 0; to = 1'b1;
    prev_sclk = 1'b0; prev_sel = sel;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        dones++;
        to = 1'b0;
        break;
      end
      if (busy) cyc++;
      if (sclk && !prev_sclk) begin
        if (sel) begin dw = {dw[14:0], mosi}; nd++; end
        else begin sw = {sw[86:0], mosi}; ns++; end
      end
      if (busy && sel && !sclk && !mosi && nd == 16 && ns == 0) gap++;
      if (sel != prev_sel && sclk) selviol++;
      if (wr_mid && cyc == 20) begin dyn_wr = 1'b1; dyn_wdata = 16'hFFFF; end
      else dyn_wr = 1'b0;
      prev_sclk = sclk; prev_sel = sel;
      @(negedge clk);
    end
    dyn_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  task automatic wait_busy(input int max_cyc, output int n, output bit sclk_seen,
                           output int dones_seen, output bit found);
    n = 0; sclk_seen = 1'b0; dones_seen = 0; found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      n++;
      if (sclk) sclk_seen = 1'b1;
      if (done) dones_seen++;
      if (busy) begin found = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {sclk, sel, mosi, busy, done}, 5'b01000);
    rst_n = 1'b1;
  endtask

  vec_t        vecs[4];
  int          nd, ns, cyc, gap, dones, selviol, n, dn;
  logic [15:0] dw;
  logic [87:0] sw;
  bit          to, sseen, found;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; flag_input = 1'b0; mode = 2'b00; dyn_wr = 1'b0; dyn_wdata = '0;

    vecs[0] = '{2'b00, 1'b0, 16'h0000, 16, 16'hABC6, 88, STAT_WORD, 840, 8};
    vecs[1] = '{2'b01, 1'b1, 16'h1234, 16, 16'h1234, 0, 88'h0, 128, 0};
    vecs[2] = '{2'b10, 1'b0, 16'h0000, 0, 16'h0000, 88, STAT_WORD, 704, 0};
    vecs[3] = '{2'b11, 1'b1, 16'h5A0F, 16, 16'h5A0F, 88, STAT_WORD, 840, 8};

    repeat (3) @(negedge clk);
    for (int v = 0; v < 4; v++) begin
      flag_input = 1'b0;
      do_reset();
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_idle_sel", v), {sel, busy}, 2'b00);
      if (vecs[v].wr) begin
        dyn_wr = 1'b1; dyn_wdata = vecs[v].wval;
        @(negedge clk);
        dyn_wr = 1'b0;
      end
      repeat (290) @(negedge clk);
      mode = vecs[v].mode;
      flag_input = 1'b1;
      wait_busy(10, n, sseen, dn, found);
      chk($sformatf("v%0d_start_latency", v), n, 2);
      collect(1'b0, nd, dw, ns, sw, cyc, gap, dones, selviol, to);
      $display("vec %0d mode=%0b dyn_bits=%0d dyn=%h stat_bits=%0d cycles=%0d gap=%0d dones=%0d",
               v, vecs[v].mode, nd, dw, ns, cyc, gap, dones);
      chk($sformatf("v%0d_timeout", v), to, 1'b0);
      chk($sformatf("v%0d_dyn_bits", v), nd, vecs[v].exp_nd);
      chk($sformatf("v%0d_dyn_word", v), dw, vecs[v].exp_dw);
      chk($sformatf("v%0d_stat_bits", v), ns, vecs[v].exp_ns);
      chk($sformatf("v%0d_stat_word", v), sw, vecs[v].exp_sw);
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d_gap", v), gap, vecs[v].exp_gap);
      chk($sformatf("v%0d_done_pulses", v), dones, 1);
      chk($sformatf("v%0d_sel_vs_sclk", v), selviol, 0);
      chk($sformatf("v%0d_done_state", v), {sclk, sel, mosi, busy}, 4'b0100);
    end

    // Flag high from reset, with a shadow write in the very cycle DYN is entered.
    flag_input = 1'b1; mode = 2'b00;
    do_reset();
    n = 0; sseen = 1'b0; found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      dyn_wr = 1'b0;
      if (sclk) sseen = 1'b1;
      if (busy) begin found = 1'b1; break; end
      if (n == 200) begin dyn_wr = 1'b1; dyn_wdata = 16'h0F5A; end
    end
    dyn_wr = 1'b0;
    chk("from_reset_found", found, 1'b1);
    chk("from_reset_latency", n, 201);
    chk("from_reset_no_sclk", sseen, 1'b0);
    collect(1'b0, nd, dw, ns, sw, cyc, gap, dones, selviol, to);
    $display("from_reset load dyn=%h stat_bits=%0d cycles=%0d", dw, ns, cyc);
    chk("same_cycle_write_word", dw, 16'h0F5A);
    chk("from_reset_cycles", cyc, 840);

    // Reset pulse in the middle of STAT.
    flag_input = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    flag_input = 1'b1;
    wait_busy(400, n, sseen, dn, found);
    for (int i = 0; i < 400; i++) begin
      if (busy && !sel) break;
      @(negedge clk);
    end
    chk("mid_stat_reached", {busy, sel}, 2'b10);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_stat_reset_outputs", {sclk, sel, mosi, busy, done}, 5'b01000);
    wait_busy(400, n, sseen, dn, found);
    $display("after mid_stat reset restart after %0d cycles dones=%0d", n, dn);
    chk("mid_stat_no_done", dn, 0);
    chk("mid_stat_full_wait", n, 201);
    chk("mid_stat_no_sclk", sseen, 1'b0);

    // Write during DYN is ignored; then try a second load.
    flag_input = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    dyn_wr = 1'b1; dyn_wdata = 16'h1234;
    @(negedge clk);
    dyn_wr = 1'b0;
    repeat (250) @(negedge clk);
    mode = 2'b01; flag_input = 1'b1;
    wait_busy(10, n, sseen, dn, found);
    collect(1'b1, nd, dw, ns, sw, cyc, gap, dones, selviol, to);
    $display("mid_dyn_write load dyn=%h bits=%0d stat_bits=%0d", dw, nd, ns);
    chk("mid_dyn_write_word", dw, 16'h1234);
    chk("mid_dyn_write_stat_bits", ns, 0);
    flag_input = 1'b0;
    repeat (3) @(negedge clk);
    flag_input = 1'b1;
    wait_busy(600, n, sseen, dn, found);
    $display("second load found=%0d after %0d cycles", found, n);
`ifdef CFG_LOADER_REPEAT_EN
    chk("repeat_found", found, 1'b1);
    chk("repeat_waited", (n >= 200), 1'b1);
    if (found) begin
      collect(1'b0, nd, dw, ns, sw, cyc, gap, dones, selviol, to);
      chk("repeat_word", dw, 16'h1234);
      chk("repeat_bits", nd, 16);
    end
`else
    chk("no_second_load", found, 1'b0);
    chk("no_second_load_sclk", sseen, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_shift_loader.md
# cfg_shift_loader

Parametrised serial configuration loader for the bridge ASIC. It shifts a dynamic word and then a static word MSB-first onto MOSI, and drives the register-select line SEL and a generated serial clock SCLK. Everything runs from a single system clock; SCLK is derived internally by division instead of coming from a second, slower clock. It sits between the start/flag logic and the on-chip static/dynamic shift registers, adds run-time update of the dynamic word and load-mode selection, and can optionally re-arm for repeated loads.

## Interface
- DYN_W, 16: dynamic word length in bits (≥2)
- STAT_W, 88: static word length in bits (≥2)
- DYN_INIT, 16'hABC6: dynamic shadow-register value at reset
- STAT_INIT, 88'h123456789ABCDEF1234567: static word (constant)
- IDLE_WAIT, 200: CLK cycles spent in IDLE before start is honoured
- CLK_DIV, 4: CLK cycles per SCLK half-period (≥1)
- CLK  in  1  system clock; all logic on its rising edge
- RST_N  in  1  reset, synchronous, active-low
- flag_input  in  1  start request (level); registered once before use
- mode  in  2  00 = dyn then stat, 01 = dyn only, 10 = stat only, 11 = same as 00; sampled on start acceptance
- dyn_wr  in  1  write strobe for the dynamic shadow register
- dyn_wdata  in  DYN_W  new dynamic word
- SCLK  out  1  serial clock to the shift registers
- SEL  out  1  register select: 1 = dynamic, 0 = static
- MOSI  out  1  serial data
- busy  out  1  high in DYN, GAP and STAT
- done  out  1  one-cycle pulse when a load completes

## Operation
- Reset (RST_N low at a CLK edge) values: SCLK=0, SEL=1, MOSI=0, busy=0, done=0.
  - State returns to IDLE and all counters clear.
  - Dynamic shadow register returns to DYN_INIT.
  - Reset asserted mid-load aborts the load with no done pulse.
- States: IDLE, DYN, GAP, STAT, DONE.
- IDLE
  - Outputs: SEL=0, MOSI=0, SCLK=0.
  - wait_cnt increments and saturates at IDLE_WAIT.
  - Exits when flag_input_reg=1 and wait_cnt ≥ IDLE_WAIT.
  - Exit target: STAT if mode=10, otherwise DYN.
- DYN
  - Copies the shadow register into the dynamic shift register on entry.
  - SEL=1; shifts DYN_W bits.
  - Exits to GAP if mode is 00 or 11; to DONE if mode=01.
- GAP
  - SEL=1, MOSI=0, SCLK=0.
  - Lasts 2·CLK_DIV CLK cycles, then goes to STAT.
- STAT
  - Loads STAT_INIT on entry.
  - SEL=0; shifts STAT_W bits.
  - Exits to DONE.
- DONE
  - SEL=1, MOSI=0, SCLK=0.
  - done pulses on the first cycle only.
- Shadow-register writes
  - dyn_wr is accepted only in IDLE or DONE.
  - It is ignored while busy=1; the current load is unaffected.
  - A write in the same cycle as the IDLE→DYN transition is accepted and the new value is shifted.
- Widths
  - Divider counter: $clog2(CLK_DIV) bits.
  - Bit counter: $clog2(max(DYN_W,STAT_W)+1) bits.
  - wait_cnt: $clog2(IDLE_WAIT+1) bits.
  - No counter wraps; each is cleared on state entry.

## Timing
- flag_input → state change: 1 registration cycle plus 1 transition cycle, once the IDLE wait has elapsed.
- Entry into DYN or STAT at cycle T:
  - MOSI = MSB and SCLK=0 from T.
  - SCLK rises at T+CLK_DIV and falls at T+2·CLK_DIV.
  - MOSI advances to the next bit on each SCLK falling edge, so it is stable around each rising edge.
- Length per word: exactly W rising edges; state length is W·2·CLK_DIV cycles.
  - The final falling edge coincides with the state exit; MOSI=0 from then on.
- SCLK toggles only in DYN and STAT; it is 0 in every other state.
- SEL changes only at state boundaries, while SCLK=0.
- Full mode-00 load: (DYN_W+1+STAT_W)·2·CLK_DIV cycles from DYN entry to DONE entry.
- done is asserted in the cycle DONE is entered.
- CLK_DIV=1: SCLK toggles every CLK cycle; the rules above still hold.

## Configuration
- CFG_LOADER_REPEAT_EN
  - Defined: DONE returns to IDLE once flag_input_reg=0. wait_cnt restarts from 0, so a new load needs a fresh IDLE_WAIT and flag_input high again.
  - Undefined: DONE is terminal until reset (one load per reset); flag_input is ignored in DONE.

## Test plan
- Default parameters, CLK_DIV=4, mode=00, flag_input high at cycle 300 → SEL=1 for 16 bits with MOSI sequence 0xABC6. Then SEL=1/MOSI=0 for 8 cycles, then SEL=0 for 88 bits of 0x123456789ABCDEF1234567. done pulses once; total 105·8 cycles.
- flag_input high from reset → DYN is entered no earlier than 200 CLK cycles after reset release plus 1; no SCLK edges before that.
- dyn_wr with 0x1234 in IDLE, mode=01 → 16 bits of 0x1234 then DONE with no static bits. A dyn_wr with 0xFFFF during DYN is ignored and the next load (REPEAT_EN) still shifts 0x1234.
- mode=10 → SEL is 0 on every SCLK rising edge, exactly 88 rising edges, no DYN phase.
- RST_N low for one cycle in the middle of STAT → next cycle SCLK=0, SEL=1, MOSI=0, busy=0, no done pulse. A new load requires the full IDLE_WAIT.
- With REPEAT_EN, flag_input toggled low then high after done → second identical load starts ≥200 cycles after DONE exit. Without it, no second load occurs.
